// File: rtl/uart_debug_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_debug_rx_if
//  Description : Byte hand-off bundle between the debug UART receiver and a
//                debug command consumer.
//                  rx_data     - received byte, stable while rx_valid=1
//                  rx_valid    - byte available, held until accepted
//                  rx_ready    - consumer accepts when valid & ready on clk
//                  frame_error - one-cycle pulse, stop bit sampled low
//                  overrun     - one-cycle pulse, completed byte dropped
//                The master modport is the receiver, the slave modport is
//                the consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_debug_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_error;
   logic       overrun;

   modport master (
      output rx_data,
      output rx_valid,
      output frame_error,
      output overrun,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  frame_error,
      input  overrun,
      output rx_ready
   );
endinterface
`default_nettype wire

// File: rtl/uart_debug_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_debug_rx
//  Description : 8N1 UART receiver for host-to-board debug commands.
//                Oversamples the raw RX pin with the system clock, samples
//                each bit at its centre and presents the byte through a
//                one-entry valid/ready holding register.
//  Ports       : clk     - system clock (27 MHz on the target board)
//                reset_n - asynchronous active-low reset
//                uart_rx - raw serial line, idle high, asynchronous to clk
//                rx_bus  - uart_debug_rx_if.master (data, valid/ready,
//                          frame_error and overrun pulses)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_debug_rx #(
   parameter int BAUD_DIVISOR = 234,
   parameter int HALF_BIT     = BAUD_DIVISOR / 2
) (
   input  wire logic         clk,
   input  wire logic         reset_n,
   input  wire logic         uart_rx,
   uart_debug_rx_if.master   rx_bus
);

   localparam int CNT_W = ($clog2(BAUD_DIVISOR) > 8) ? $clog2(BAUD_DIVISOR) : 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   baud_cnt, baud_cnt_nxt;
   logic [2:0]         bit_idx, bit_idx_nxt;
   logic [7:0]         shift, shift_nxt;
   logic               sync1, sync2, rx_prev;
   logic               rx_s, fall;
   logic               byte_done, ferr_set;
   logic [7:0]         data_q;
   logic               valid_q, ferr_q, ovr_q;

   // Synchronizer and edge-history flops preset high so that releasing
   // reset with an idle line never looks like a start edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= uart_rx;
         sync2   <= sync1;
         rx_prev <= sync2;
      end
   end

   assign rx_s = sync2;
   assign fall = rx_prev & ~rx_s;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         shift    <= shift_nxt;
      end
   end

   // Next-state logic. The baud counter restarts at every sample point so
   // that each subsequent sample lands a full bit period later, i.e. in the
   // centre of the next bit.
   always_comb begin
      state_nxt    = state;
      baud_cnt_nxt = baud_cnt;
      bit_idx_nxt  = bit_idx;
      shift_nxt    = shift;
      byte_done    = 1'b0;
      ferr_set     = 1'b0;
      case (state)
         IDLE: begin
            if (fall) begin
               state_nxt    = START;
               baud_cnt_nxt = '0;
            end
         end
         START: begin
            if (baud_cnt == CNT_W'(HALF_BIT - 1)) begin
               baud_cnt_nxt = '0;
               bit_idx_nxt  = '0;
               // Line back high at mid start bit: a glitch, not a frame.
               state_nxt    = rx_s ? IDLE : DATA;
            end else begin
               baud_cnt_nxt = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            if (baud_cnt == CNT_W'(BAUD_DIVISOR - 1)) begin
               baud_cnt_nxt = '0;
               shift_nxt    = {rx_s, shift[7:1]};
               bit_idx_nxt  = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_nxt = STOP;
               end
            end else begin
               baud_cnt_nxt = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            if (baud_cnt == CNT_W'(BAUD_DIVISOR - 1)) begin
               baud_cnt_nxt = '0;
               if (rx_s) begin
                  byte_done = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ferr_set  = 1'b1;
                  state_nxt = BREAK;
               end
            end else begin
               baud_cnt_nxt = baud_cnt + 1'b1;
            end
         end
         BREAK: begin
            // Held-low line: report once, then wait for the line to idle.
            if (rx_s) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // One-entry holding register. A byte completing in the same cycle as a
   // handshake replaces the accepted one without a bubble.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ferr_q <= ferr_set;
         ovr_q  <= 1'b0;
         if (byte_done) begin
            if (!valid_q || rx_bus.rx_ready) begin
               data_q  <= shift;
               valid_q <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end else if (valid_q && rx_bus.rx_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rx_bus.rx_data     = data_q;
   assign rx_bus.rx_valid    = valid_q;
   assign rx_bus.frame_error = ferr_q;
   assign rx_bus.overrun     = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_debug_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_debug_rx
//  Description : Directed bench for uart_debug_rx. Drives 8N1 frames on the
//                serial pin and checks received bytes, handshake, frame
//                error, overrun and reset behaviour against hand-computed
//                values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_debug_rx;

   localparam int BAUD = 234;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic uart_rx = 1'b1;
   int   cyc = 0;

   int   vectors = 0;
   int   miscompares = 0;

   // Observation state, written only by the monitor process.
   logic [7:0] got[$];
   int   ferr_cnt = 0;
   int   ovr_cnt = 0;
   int   rise_cnt = 0;
   int   rise_cyc = 0;
   logic valid_d = 1'b0;

   int   start_cyc;

   uart_debug_rx_if bus ();

   uart_debug_rx #(.BAUD_DIVISOR(BAUD)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .uart_rx (uart_rx),
      .rx_bus  (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.rx_valid && bus.rx_ready) got.push_back(bus.rx_data);
      if (bus.frame_error) ferr_cnt <= ferr_cnt + 1;
      if (bus.overrun) ovr_cnt <= ovr_cnt + 1;
      if (bus.rx_valid && !valid_d) begin
         rise_cnt <= rise_cnt + 1;
         rise_cyc <= cyc;
      end
      valid_d <= bus.rx_valid;
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic v);
      uart_rx = v;
      idle(BAUD);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop);
      start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop);
      uart_rx = 1'b1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      bus.rx_ready = 1'b0;
      idle(3);
      @(negedge clk);
      vectors++;
      if (bus.rx_data !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_data got=%h exp=00", bus.rx_data);
      end
      vectors++;
      if ({bus.rx_valid, bus.frame_error, bus.overrun} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_flags got v/fe/ov=%b exp=000",
                  {bus.rx_valid, bus.frame_error, bus.overrun});
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      idle(20);
      vectors++;
      if (rise_cnt !== 0 || ferr_cnt !== 0) begin
         miscompares++;
         $display("FAIL reset_release got rises=%0d ferr=%0d exp=0/0", rise_cnt, ferr_cnt);
      end
   endtask

   task automatic test_single_55;
      int qb, fb, ob, rb, dt;
      bus.rx_ready = 1'b1;
      qb = got.size(); fb = ferr_cnt; ob = ovr_cnt; rb = rise_cnt;
      send_byte(8'h55, 1'b1);
      idle(300);
      vectors++;
      if (got.size() - qb !== 1 || rise_cnt - rb !== 1) begin
         miscompares++;
         $display("FAIL single_count got bytes=%0d rises=%0d exp=1/1", got.size() - qb, rise_cnt - rb);
      end else begin
         vectors++;
         if (got[qb] !== 8'h55) begin
            miscompares++;
            $display("FAIL single_data got=%h exp=55", got[qb]);
         end
      end
      dt = rise_cyc - start_cyc;
      vectors++;
      if (dt < 2224 || dt > 2228) begin
         miscompares++;
         $display("FAIL single_latency got=%0d exp=2226+-2", dt);
      end
      vectors++;
      if (ferr_cnt - fb !== 0 || ovr_cnt - ob !== 0) begin
         miscompares++;
         $display("FAIL single_errors got ferr=%0d ovr=%0d exp=0/0", ferr_cnt - fb, ovr_cnt - ob);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] msg [7];
      int qb, fb, ob;
      msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};
      bus.rx_ready = 1'b1;
      qb = got.size(); fb = ferr_cnt; ob = ovr_cnt;
      for (int i = 0; i < 7; i++) send_byte(msg[i], 1'b1);
      idle(300);
      vectors++;
      if (got.size() - qb !== 7) begin
         miscompares++;
         $display("FAIL hello_count got=%0d exp=7", got.size() - qb);
      end else begin
         for (int i = 0; i < 7; i++) begin
            vectors++;
            if (got[qb + i] !== msg[i]) begin
               miscompares++;
               $display("FAIL hello_byte%0d got=%h exp=%h", i, got[qb + i], msg[i]);
            end
         end
      end
      vectors++;
      if (ferr_cnt - fb !== 0 || ovr_cnt - ob !== 0) begin
         miscompares++;
         $display("FAIL hello_errors got ferr=%0d ovr=%0d exp=0/0", ferr_cnt - fb, ovr_cnt - ob);
      end
   endtask

   task automatic test_glitch;
      int qb, fb, rb;
      bus.rx_ready = 1'b1;
      qb = got.size(); fb = ferr_cnt; rb = rise_cnt;
      uart_rx = 1'b0;
      idle(50);
      uart_rx = 1'b1;
      idle(400);
      vectors++;
      if (rise_cnt - rb !== 0 || ferr_cnt - fb !== 0) begin
         miscompares++;
         $display("FAIL glitch_quiet got rises=%0d ferr=%0d exp=0/0", rise_cnt - rb, ferr_cnt - fb);
      end
      send_byte(8'hA5, 1'b1);
      idle(300);
      vectors++;
      if (got.size() - qb !== 1) begin
         miscompares++;
         $display("FAIL glitch_next_count got=%0d exp=1", got.size() - qb);
      end else begin
         vectors++;
         if (got[qb] !== 8'hA5) begin
            miscompares++;
            $display("FAIL glitch_next_data got=%h exp=a5", got[qb]);
         end
      end
   endtask

   task automatic test_frame_error;
      int qb, fb, rb;
      bus.rx_ready = 1'b1;
      qb = got.size(); fb = ferr_cnt; rb = rise_cnt;
      send_byte(8'h00, 1'b0);
      uart_rx = 1'b0;
      idle(5000);
      uart_rx = 1'b1;
      idle(300);
      vectors++;
      if (ferr_cnt - fb !== 1) begin
         miscompares++;
         $display("FAIL ferr_pulses got=%0d exp=1", ferr_cnt - fb);
      end
      vectors++;
      if (rise_cnt - rb !== 0) begin
         miscompares++;
         $display("FAIL ferr_no_valid got rises=%0d exp=0", rise_cnt - rb);
      end
      send_byte(8'h3C, 1'b1);
      idle(300);
      vectors++;
      if (got.size() - qb !== 1) begin
         miscompares++;
         $display("FAIL ferr_next_count got=%0d exp=1", got.size() - qb);
      end else begin
         vectors++;
         if (got[qb] !== 8'h3C) begin
            miscompares++;
            $display("FAIL ferr_next_data got=%h exp=3c", got[qb]);
         end
      end
   endtask

   task automatic test_overrun;
      int ob;
      bus.rx_ready = 1'b0;
      ob = ovr_cnt;
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      idle(300);
      @(negedge clk);
      vectors++;
      if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h11) begin
         miscompares++;
         $display("FAIL ovr_hold got v=%b d=%h exp v=1 d=11", bus.rx_valid, bus.rx_data);
      end
      vectors++;
      if (ovr_cnt - ob !== 1) begin
         miscompares++;
         $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt - ob);
      end
      @(posedge clk); #1;
      bus.rx_ready = 1'b1;
      @(posedge clk); #1;
      bus.rx_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.rx_valid !== 1'b0 || bus.rx_data !== 8'h11) begin
         miscompares++;
         $display("FAIL ovr_accept got v=%b d=%h exp v=0 d=11", bus.rx_valid, bus.rx_data);
      end
   endtask

   task automatic test_reset_midframe;
      int rb, fb;
      // Park a byte in the holding register so reset has something to clear.
      bus.rx_ready = 1'b0;
      send_byte(8'h99, 1'b1);
      idle(300);
      // 0x7E: start, bit0=0, bits1..3=1, then into the middle of bit 4.
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b1);
      uart_rx = 1'b1;
      idle(BAUD / 2);
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if ({bus.rx_data, bus.rx_valid, bus.frame_error, bus.overrun} !== 11'h000) begin
            miscompares++;
            $display("FAIL midreset_cycle%0d got d=%h v/fe/ov=%b exp d=00 000", i,
                     bus.rx_data, {bus.rx_valid, bus.frame_error, bus.overrun});
         end
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      rb = rise_cnt; fb = ferr_cnt;
      idle(3000);
      vectors++;
      if (rise_cnt - rb !== 0 || ferr_cnt - fb !== 0 || bus.rx_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_quiet got rises=%0d ferr=%0d v=%b exp=0/0/0",
                  rise_cnt - rb, ferr_cnt - fb, bus.rx_valid);
      end
      send_byte(8'hC3, 1'b1);
      idle(300);
      @(negedge clk);
      vectors++;
      if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'hC3) begin
         miscompares++;
         $display("FAIL midreset_next got v=%b d=%h exp v=1 d=c3", bus.rx_valid, bus.rx_data);
      end
   endtask

   initial begin
      bus.rx_ready = 1'b0;
      test_reset();
      test_single_55();
      test_back_to_back();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
